// File: rtl/keccak_core_arbiter.sv
// keccak_core_arbiter
// Shares one Keccak-f[1600] permutation core between NREQ requesters. One
// requester at a time owns the core for a session (round-robin grant). The
// owner's state-word writes, reads and permutation start are forwarded to the
// core, and the core's completion is returned to the owner as a done pulse.
//
// Ports (per-requester buses are flat-packed, requester k at [k*W +: W]):
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   req_i / gnt_o              session request (level) / one-hot grant (level)
//   release_i                  end-of-session pulse from the owner
//   wr_en_i/wr_addr_i/wr_data_i  state-word write command
//   start_i / done_o           permutation start pulse / completion pulse
//   rd_addr_i / rd_data_o      state-word read (combinational through core)
//   err_o                      dropped-command pulse to the owner
//   core_*                     core state register file and start/done handshake
//   busy_o                     permutation in flight
module keccak_core_arbiter #(
    parameter int NREQ   = 2,
    parameter int DW     = 32,
    parameter int NWORDS = 50,
    parameter int AW     = 6
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NREQ-1:0]    req_i,
    input  logic [NREQ-1:0]    release_i,
    output logic [NREQ-1:0]    gnt_o,
    input  logic [NREQ-1:0]    wr_en_i,
    input  logic [NREQ*AW-1:0] wr_addr_i,
    input  logic [NREQ*DW-1:0] wr_data_i,
    input  logic [NREQ-1:0]    start_i,
    input  logic [NREQ*AW-1:0] rd_addr_i,
    output logic [NREQ*DW-1:0] rd_data_o,
    output logic [NREQ-1:0]    done_o,
    output logic [NREQ-1:0]    err_o,
    output logic               core_wr_en_o,
    output logic [AW-1:0]      core_addr_o,
    output logic [DW-1:0]      core_wdata_o,
    input  logic [DW-1:0]      core_rdata_i,
    output logic               core_start_o,
    input  logic               core_done_i,
    output logic               busy_o
);

    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [AW:0] NWORDS_W = (AW+1)'(NWORDS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWNED = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   rr_q, rr_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [NREQ-1:0] err_q, err_d;
    logic            wr_en_q, wr_en_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            start_q, start_d;
    logic            start_pend_q, start_pend_d;
    logic            busy_q, busy_d;

    logic [OW-1:0]   win_s, hi_idx_s, lo_idx_s, rr_next_s;
    logic            hi_found_s;
    logic            own_wr_s, own_start_s, own_rel_s, own_addr_ok_s;
    logic [AW-1:0]   own_waddr_s, own_raddr_s;
    logic [DW-1:0]   own_wdata_s;

    // Select the owner's command slices and compute the next round-robin pointer.
    always_comb begin
        own_wr_s      = wr_en_i[owner_q];
        own_start_s   = start_i[owner_q];
        own_rel_s     = release_i[owner_q];
        own_waddr_s   = wr_addr_i[int'(owner_q)*AW +: AW];
        own_wdata_s   = wr_data_i[int'(owner_q)*DW +: DW];
        own_raddr_s   = rd_addr_i[int'(owner_q)*AW +: AW];
        own_addr_ok_s = ({1'b0, own_waddr_s} < NWORDS_W);
        rr_next_s     = (owner_q == OW'(NREQ-1)) ? '0 : owner_q + OW'(1);
    end

    // Round-robin winner: lowest requester at or above rr_q, else lowest overall.
    // The loop runs downward so the last hit is the lowest index.
    always_comb begin
        hi_idx_s   = '0;
        lo_idx_s   = '0;
        hi_found_s = 1'b0;
        for (int k = NREQ-1; k >= 0; k--) begin
            lo_idx_s   = req_i[k] ? OW'(k) : lo_idx_s;
            hi_idx_s   = (req_i[k] && (k >= int'(rr_q))) ? OW'(k) : hi_idx_s;
            hi_found_s = (req_i[k] && (k >= int'(rr_q))) ? 1'b1 : hi_found_s;
        end
        win_s = hi_found_s ? hi_idx_s : lo_idx_s;
    end

    // Session state machine: next-state and next registered outputs.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        rr_d         = rr_q;
        gnt_d        = gnt_q;
        done_d       = '0;
        err_d        = '0;
        wr_en_d      = 1'b0;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        // A start that arrived together with a write is issued one cycle late
        // so the write reaches the core first.
        start_d      = start_pend_q;
        start_pend_d = 1'b0;
        busy_d       = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (|req_i) begin
                    owner_d = win_s;
                    gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << win_s;
                    state_d = ST_OWNED;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OWNED: begin
                if (own_wr_s && own_addr_ok_s) begin
                    wr_en_d = 1'b1;
                    waddr_d = own_waddr_s;
                    wdata_d = own_wdata_s;
                end else if (own_wr_s) begin
                    err_d = gnt_q;
                end else begin
                    wr_en_d = 1'b0;
                end
                // Start takes priority over release; a simultaneous release
                // behaves as a release during the permutation.
                if (own_start_s) begin
                    start_d      = !(own_wr_s && own_addr_ok_s);
                    start_pend_d = own_wr_s && own_addr_ok_s;
                    busy_d       = 1'b1;
                    state_d      = own_rel_s ? ST_DRAIN : ST_RUN;
                end else if (own_rel_s) begin
                    gnt_d   = '0;
                    rr_d    = rr_next_s;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_OWNED;
                end
            end
            ST_RUN, ST_DRAIN: begin
                err_d = (own_wr_s || own_start_s) ? gnt_q : '0;
                if (core_done_i) begin
                    done_d = gnt_q;
                    busy_d = 1'b0;
                    if ((state_q == ST_DRAIN) || own_rel_s) begin
                        gnt_d   = '0;
                        rr_d    = rr_next_s;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_OWNED;
                    end
                end else if ((state_q == ST_RUN) && own_rel_s) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered-output flops.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            owner_q      <= '0;
            rr_q         <= '0;
            gnt_q        <= '0;
            done_q       <= '0;
            err_q        <= '0;
            wr_en_q      <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            start_q      <= 1'b0;
            start_pend_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            rr_q         <= rr_d;
            gnt_q        <= gnt_d;
            done_q       <= done_d;
            err_q        <= err_d;
            wr_en_q      <= wr_en_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            start_q      <= start_d;
            start_pend_q <= start_pend_d;
            busy_q       <= busy_d;
        end
    end

    // Core address: a pending write owns the port; otherwise the owner reads.
    // Read data reaches only the owner and is blanked while a write is pending.
    always_comb begin
        core_addr_o = wr_en_q ? waddr_q : ((|gnt_q) ? own_raddr_s : '0);
        rd_data_o   = '0;
        for (int k = 0; k < NREQ; k++) begin
            rd_data_o[k*DW +: DW] = (gnt_q[k] && !wr_en_q) ? core_rdata_i : '0;
        end
    end

    assign gnt_o        = gnt_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign core_wr_en_o = wr_en_q;
    assign core_wdata_o = wdata_q;
    assign core_start_o = start_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_keccak_core_arbiter.sv
`timescale 1ns/1ps
module tb_keccak_core_arbiter;

    localparam int NREQ   = 2;
    localparam int DW     = 32;
    localparam int NWORDS = 50;
    localparam int AW     = 6;

    logic               clk_i = 1'b0;
    logic               rst_ni = 1'b0;
    logic [NREQ-1:0]    req_i = '0;
    logic [NREQ-1:0]    release_i = '0;
    logic [NREQ-1:0]    gnt_o;
    logic [NREQ-1:0]    wr_en_i = '0;
    logic [NREQ*AW-1:0] wr_addr_i = '0;
    logic [NREQ*DW-1:0] wr_data_i = '0;
    logic [NREQ-1:0]    start_i = '0;
    logic [NREQ*AW-1:0] rd_addr_i = '0;
    logic [NREQ*DW-1:0] rd_data_o;
    logic [NREQ-1:0]    done_o;
    logic [NREQ-1:0]    err_o;
    logic               core_wr_en_o;
    logic [AW-1:0]      core_addr_o;
    logic [DW-1:0]      core_wdata_o;
    logic [DW-1:0]      core_rdata_i;
    logic               core_start_o;
    logic               core_done_i = 1'b0;
    logic               busy_o;

    int n_checks = 0;
    int n_fails  = 0;
    logic [AW+DW-1:0] sb_q[$];
    logic [AW+DW-1:0] sb_exp;

    // Behavioural core state file: written on core strobes, read combinationally.
    logic [DW-1:0] mem [0:63] = '{default: '0};
    assign core_rdata_i = mem[core_addr_o];
    always @(posedge clk_i) begin
        if (core_wr_en_o) mem[core_addr_o] <= core_wdata_o;
    end

    always #5 clk_i = ~clk_i;

    keccak_core_arbiter #(.NREQ(NREQ), .DW(DW), .NWORDS(NWORDS), .AW(AW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .release_i(release_i),
        .gnt_o(gnt_o), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
        .start_i(start_i), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
        .done_o(done_o), .err_o(err_o), .core_wr_en_o(core_wr_en_o),
        .core_addr_o(core_addr_o), .core_wdata_o(core_wdata_o),
        .core_rdata_i(core_rdata_i), .core_start_o(core_start_o),
        .core_done_i(core_done_i), .busy_o(busy_o)
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        req_i = '0; release_i = '0; wr_en_i = '0; start_i = '0;
        wr_addr_i = '0; wr_data_i = '0; rd_addr_i = '0; core_done_i = 1'b0;
        rst_ni = 1'b0;
        step();
        step();
        rst_ni = 1'b1;
        step();
        sb_q.delete();
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        rd_addr_i = {6'd9, 6'd5};
        step();
        step();
        n_checks++; if (gnt_o !== 2'b00) begin n_fails++; $display("FAIL rst_gnt: got %b expected 00", gnt_o); end
        n_checks++; if ({busy_o, core_start_o, core_wr_en_o} !== 3'b000) begin n_fails++; $display("FAIL rst_ctrl: got %b expected 000", {busy_o, core_start_o, core_wr_en_o}); end
        n_checks++; if ({done_o, err_o} !== 4'b0000) begin n_fails++; $display("FAIL rst_pulses: got %b expected 0000", {done_o, err_o}); end
        n_checks++; if (core_addr_o !== 6'd0 || core_wdata_o !== 32'd0) begin n_fails++; $display("FAIL rst_core_bus: got addr %0d data %0h expected 0 0", core_addr_o, core_wdata_o); end
        n_checks++; if (rd_data_o !== 64'd0) begin n_fails++; $display("FAIL rst_rd_data: got %0h expected 0", rd_data_o); end
        do_reset();
    endtask

    task automatic test_single_session();
        req_i = 2'b01;
        step();
        n_checks++; if (gnt_o !== 2'b01) begin n_fails++; $display("FAIL ss_grant: got %b expected 01", gnt_o); end
        req_i = 2'b00;
        for (int a = 0; a < NWORDS; a++) begin
            wr_en_i = 2'b01;
            wr_addr_i[5:0] = 6'(a);
            wr_data_i[31:0] = 32'(a * 3);
            sb_q.push_back({6'(a), 32'(a * 3)});
            step();
            n_checks++;
            if (core_wr_en_o !== 1'b1 || sb_q.size() == 0) begin
                n_fails++; $display("FAIL ss_write_strobe: got %b expected 1 (word %0d)", core_wr_en_o, a);
            end else begin
                sb_exp = sb_q.pop_front();
                if ({core_addr_o, core_wdata_o} !== sb_exp) begin
                    n_fails++; $display("FAIL ss_write_data: got %0h expected %0h", {core_addr_o, core_wdata_o}, sb_exp);
                end
            end
        end
        wr_en_i = 2'b00;
        step();
        n_checks++; if (core_wr_en_o !== 1'b0 || err_o !== 2'b00) begin n_fails++; $display("FAIL ss_write_end: got %b/%b expected 0/00", core_wr_en_o, err_o); end
        rd_addr_i[5:0] = 6'd7;
        #1;
        n_checks++; if (rd_data_o !== {32'd0, 32'd21}) begin n_fails++; $display("FAIL ss_read7: got %0h expected 21", rd_data_o); end
        start_i = 2'b01;
        step();
        n_checks++; if (core_start_o !== 1'b1 || busy_o !== 1'b1) begin n_fails++; $display("FAIL ss_start: got start %b busy %b expected 1 1", core_start_o, busy_o); end
        start_i = 2'b00;
        step();
        n_checks++; if (core_start_o !== 1'b0 || busy_o !== 1'b1) begin n_fails++; $display("FAIL ss_start_pulse: got start %b busy %b expected 0 1", core_start_o, busy_o); end
        for (int i = 0; i < 22; i++) step();
        core_done_i = 1'b1;
        step();
        core_done_i = 1'b0;
        n_checks++; if (done_o !== 2'b01 || busy_o !== 1'b0 || gnt_o !== 2'b01) begin n_fails++; $display("FAIL ss_done: got done %b busy %b gnt %b expected 01 0 01", done_o, busy_o, gnt_o); end
        step();
        n_checks++; if (done_o !== 2'b00) begin n_fails++; $display("FAIL ss_done_pulse: got %b expected 00", done_o); end
        release_i = 2'b01;
        step();
        release_i = 2'b00;
        n_checks++; if (gnt_o !== 2'b00) begin n_fails++; $display("FAIL ss_release: got %b expected 00", gnt_o); end
        step();
    endtask

    task automatic test_round_robin();
        do_reset();
        req_i = 2'b11;
        step();
        n_checks++; if (gnt_o !== 2'b01) begin n_fails++; $display("FAIL rr_first: got %b expected 01", gnt_o); end
        release_i = 2'b01;
        step();
        release_i = 2'b00;
        n_checks++; if (gnt_o !== 2'b00) begin n_fails++; $display("FAIL rr_idle_gap: got %b expected 00", gnt_o); end
        step();
        n_checks++; if (gnt_o !== 2'b10) begin n_fails++; $display("FAIL rr_second: got %b expected 10", gnt_o); end
        release_i = 2'b10;
        step();
        release_i = 2'b00;
        step();
        n_checks++; if (gnt_o !== 2'b01) begin n_fails++; $display("FAIL rr_wrap: got %b expected 01", gnt_o); end
        req_i = 2'b00;
    endtask

    task automatic test_illegal();
        do_reset();
        req_i = 2'b01;
        step();
        req_i = 2'b00;
        wr_en_i = 2'b01; wr_addr_i[5:0] = 6'd50; wr_data_i[31:0] = 32'hBAD0BAD0;
        step();
        wr_en_i = 2'b00;
        n_checks++; if (core_wr_en_o !== 1'b0 || err_o !== 2'b01) begin n_fails++; $display("FAIL il_addr50: got wr %b err %b expected 0 01", core_wr_en_o, err_o); end
        step();
        n_checks++; if (err_o !== 2'b00) begin n_fails++; $display("FAIL il_err_pulse: got %b expected 00", err_o); end
        wr_en_i = 2'b10; wr_addr_i[11:6] = 6'd5; start_i = 2'b10; release_i = 2'b10;
        step();
        wr_en_i = 2'b00; start_i = 2'b00; release_i = 2'b00;
        n_checks++; if ({core_wr_en_o, core_start_o, busy_o, err_o, gnt_o} !== 7'b0000001) begin n_fails++; $display("FAIL il_nonowner: got %b expected 0000001", {core_wr_en_o, core_start_o, busy_o, err_o, gnt_o}); end
        start_i = 2'b01;
        step();
        start_i = 2'b00;
        step();
        wr_en_i = 2'b01; wr_addr_i[5:0] = 6'd3; wr_data_i[31:0] = 32'h12345678;
        step();
        wr_en_i = 2'b00;
        n_checks++; if (core_wr_en_o !== 1'b0 || err_o !== 2'b01) begin n_fails++; $display("FAIL il_run_write: got wr %b err %b expected 0 01", core_wr_en_o, err_o); end
        rd_addr_i[5:0] = 6'd7;
        #1;
        n_checks++; if (rd_data_o !== {32'd0, 32'd21}) begin n_fails++; $display("FAIL il_run_read: got %0h expected 21", rd_data_o); end
        core_done_i = 1'b1;
        step();
        core_done_i = 1'b0;
        n_checks++; if (done_o !== 2'b01) begin n_fails++; $display("FAIL il_done: got %b expected 01", done_o); end
        release_i = 2'b01;
        step();
        release_i = 2'b00;
    endtask

    task automatic test_release_in_run();
        do_reset();
        req_i = 2'b11;
        step();
        req_i = 2'b10;
        start_i = 2'b01;
        step();
        start_i = 2'b00;
        for (int i = 0; i < 4; i++) step();
        release_i = 2'b01;
        step();
        release_i = 2'b00;
        n_checks++; if (gnt_o !== 2'b01 || busy_o !== 1'b1) begin n_fails++; $display("FAIL rel_run_hold: got gnt %b busy %b expected 01 1", gnt_o, busy_o); end
        step();
        step();
        core_done_i = 1'b1;
        step();
        core_done_i = 1'b0;
        n_checks++; if (done_o !== 2'b01 || gnt_o !== 2'b00 || busy_o !== 1'b0) begin n_fails++; $display("FAIL rel_run_done: got done %b gnt %b busy %b expected 01 00 0", done_o, gnt_o, busy_o); end
        step();
        n_checks++; if (gnt_o !== 2'b10 || done_o !== 2'b00) begin n_fails++; $display("FAIL rel_run_next: got gnt %b done %b expected 10 00", gnt_o, done_o); end
        req_i = 2'b00;
        release_i = 2'b10;
        step();
        release_i = 2'b00;
    endtask

    task automatic test_write_start_and_reset();
        do_reset();
        req_i = 2'b01;
        step();
        req_i = 2'b00;
        wr_en_i = 2'b01; wr_addr_i[5:0] = 6'd49; wr_data_i[31:0] = 32'hDEADBEEF; start_i = 2'b01;
        sb_q.push_back({6'd49, 32'hDEADBEEF});
        step();
        wr_en_i = 2'b00; start_i = 2'b00;
        n_checks++;
        if (core_wr_en_o !== 1'b1 || core_start_o !== 1'b0 || sb_q.size() == 0) begin
            n_fails++; $display("FAIL ws_write_first: got wr %b start %b expected 1 0", core_wr_en_o, core_start_o);
        end else begin
            sb_exp = sb_q.pop_front();
            if ({core_addr_o, core_wdata_o} !== sb_exp) begin n_fails++; $display("FAIL ws_write_data: got %0h expected %0h", {core_addr_o, core_wdata_o}, sb_exp); end
        end
        step();
        n_checks++; if (core_start_o !== 1'b1 || core_wr_en_o !== 1'b0 || busy_o !== 1'b1) begin n_fails++; $display("FAIL ws_start_second: got start %b wr %b busy %b expected 1 0 1", core_start_o, core_wr_en_o, busy_o); end
        for (int i = 0; i < 8; i++) step();
        #3;
        rst_ni = 1'b0;
        #1;
        n_checks++; if (gnt_o !== 2'b00 || busy_o !== 1'b0 || core_start_o !== 1'b0) begin n_fails++; $display("FAIL ar_immediate: got gnt %b busy %b start %b expected 00 0 0", gnt_o, busy_o, core_start_o); end
        step();
        rst_ni = 1'b1;
        step();
        core_done_i = 1'b1;
        step();
        core_done_i = 1'b0;
        n_checks++; if (done_o !== 2'b00 || gnt_o !== 2'b00) begin n_fails++; $display("FAIL ar_late_done: got done %b gnt %b expected 00 00", done_o, gnt_o); end
        step();
        n_checks++; if (done_o !== 2'b00 || busy_o !== 1'b0) begin n_fails++; $display("FAIL ar_quiet: got done %b busy %b expected 00 0", done_o, busy_o); end
    endtask

    initial begin
        test_reset();
        test_single_session();
        test_round_robin();
        test_illegal();
        test_release_in_run();
        test_write_start_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
